// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: streams k_len operand pairs from two sources into an external MAC and captures its sum.
// Define MAC_SEQ_PERF_EN to add the stall_cnt performance counter output.
module mac_seq_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int K_WIDTH    = 8,
    parameter int FIN_HOLD   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [K_WIDTH-1:0]    k_len,
    input  logic                  a_valid,
    input  logic                  b_valid,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  a_pop,
    output logic                  b_pop,
    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_b,
    output logic                  mac_a_waiting,
    output logic                  mac_b_waiting,
    output logic                  mac_a_finished,
    output logic                  mac_b_finished,
    input  logic                  mac_a_ready,
    input  logic                  mac_b_ready,
    input  logic [DATA_WIDTH-1:0] mac_c,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] c_result
`ifdef MAC_SEQ_PERF_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int HOLD_W = (FIN_HOLD > 1) ? $clog2(FIN_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FIN_HOLD - 1);

    typedef enum logic [2:0] {IDLE, FEED, ISSUE, FINISH, DONE} state_t;

    state_t              state_reg;
    logic [K_WIDTH-1:0]  count_reg;
    logic [HOLD_W-1:0]   hold_reg;
    logic                feed_fire;
    logic                issue_fire;
    logic                last_pair;

    assign feed_fire  = (state_reg == FEED) && a_valid && b_valid && mac_a_ready && mac_b_ready;
    // The MAC acknowledges operands by dropping both readies while we are waiting.
    assign issue_fire = (state_reg == ISSUE) && !mac_a_ready && !mac_b_ready;
    assign last_pair  = (count_reg == K_WIDTH'(1)) || (count_reg == '0);
    assign a_pop      = issue_fire;
    assign b_pop      = issue_fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            hold_reg       <= '0;
            mac_a          <= '0;
            mac_b          <= '0;
            mac_a_waiting  <= 1'b0;
            mac_b_waiting  <= 1'b0;
            mac_a_finished <= 1'b0;
            mac_b_finished <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            c_result       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        count_reg <= k_len;
                        hold_reg  <= '0;
                        busy      <= 1'b1;
                        if (k_len != '0) begin
                            state_reg <= FEED;
                        end else begin
                            state_reg      <= FINISH;
                            mac_a_finished <= 1'b1;
                            mac_b_finished <= 1'b1;
                        end
                    end
                end
                FEED: begin
                    if (feed_fire) begin
                        mac_a         <= a_data;
                        mac_b         <= b_data;
                        mac_a_waiting <= 1'b1;
                        mac_b_waiting <= 1'b1;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_fire) begin
                        mac_a_waiting <= 1'b0;
                        mac_b_waiting <= 1'b0;
                        if (count_reg != '0) begin
                            count_reg <= count_reg - K_WIDTH'(1);
                        end
                        if (last_pair) begin
                            state_reg      <= FINISH;
                            hold_reg       <= '0;
                            mac_a_finished <= 1'b1;
                            mac_b_finished <= 1'b1;
                        end else begin
                            state_reg <= FEED;
                        end
                    end
                end
                FINISH: begin
                    if (hold_reg == HOLD_LAST) begin
                        mac_a_finished <= 1'b0;
                        mac_b_finished <= 1'b0;
                        c_result       <= mac_c;
                        done           <= 1'b1;
                        state_reg      <= DONE;
                    end else begin
                        hold_reg <= hold_reg + HOLD_W'(1);
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef MAC_SEQ_PERF_EN
    logic stall_now;

    assign stall_now = ((state_reg == FEED) && !feed_fire) || ((state_reg == ISSUE) && !issue_fire);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if ((state_reg == IDLE) && start) begin
            stall_cnt <= '0;
        end else if (stall_now && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: table of directed jobs against a behavioural source/MAC model,
// plus hand-written reset-during-ISSUE sequence.
module tb_mac_seq_ctrl;
    localparam int DW = 32;
    localparam int KW = 8;
    localparam int FH = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          a_valid = 1'b0;
    logic          b_valid = 1'b0;
    logic [DW-1:0] a_data = '0;
    logic [DW-1:0] b_data = '0;
    logic          a_pop, b_pop;
    logic [DW-1:0] mac_a, mac_b;
    logic          mac_a_waiting, mac_b_waiting;
    logic          mac_a_finished, mac_b_finished;
    logic          mac_a_ready = 1'b1;
    logic          mac_b_ready = 1'b1;
    logic [DW-1:0] mac_c = '0;
    logic          busy, done;
    logic [DW-1:0] c_result;
`ifdef MAC_SEQ_PERF_EN
    logic [15:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    mac_seq_ctrl #(.DATA_WIDTH(DW), .K_WIDTH(KW), .FIN_HOLD(FH)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .a_valid(a_valid), .b_valid(b_valid), .a_data(a_data), .b_data(b_data),
        .a_pop(a_pop), .b_pop(b_pop), .mac_a(mac_a), .mac_b(mac_b),
        .mac_a_waiting(mac_a_waiting), .mac_b_waiting(mac_b_waiting),
        .mac_a_finished(mac_a_finished), .mac_b_finished(mac_b_finished),
        .mac_a_ready(mac_a_ready), .mac_b_ready(mac_b_ready), .mac_c(mac_c),
        .busy(busy), .done(done), .c_result(c_result)
`ifdef MAC_SEQ_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    typedef struct {
        int              k;
        logic [3:0][31:0] a;
        logic [3:0][31:0] b;
        int              stall;
        int              restart_at;
        logic [31:0]     exp_c;
    } vec_t;

    // Job description written only by the stimulus process.
    int               job_seq = 0;
    int               job_k = 0;
    int               job_stall = 0;
    logic [3:0][31:0] job_a = '0;
    logic [3:0][31:0] job_b = '0;

    // Model state written only by the model process.
    int          seen_seq = 0;
    int          idx = 0;
    int          wcnt = 0;
    int          cyc = 0;
    int          stall_left = 0;
    int          pop_cnt = 0;
    int          fin_cnt = 0;
    int          done_cnt = 0;
    int          wait_cycles = 0;
    int          start_cyc = 0;
    int          done_cyc = 0;
    int          proto_err = 0;
    logic [31:0] acc = '0;
    logic [31:0] first_a = '0;
    logic        exp_pop;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int k, input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [31:0] a3,
                                input logic [31:0] b0, input logic [31:0] b1,
                                input logic [31:0] b2, input logic [31:0] b3,
                                input int stall, input int rs, input logic [31:0] c);
        vec_t v;
        v.k = k;
        v.a = {a3, a2, a1, a0};
        v.b = {b3, b2, b1, b0};
        v.stall = stall;
        v.restart_at = rs;
        v.exp_c = c;
        return v;
    endfunction

    // Source streams and a MAC that acknowledges two cycles after seeing waiting.
    always @(negedge clk) begin
        if (!rst) begin
            mac_a_ready = 1'b1;
            mac_b_ready = 1'b1;
            wcnt = 0;
        end else begin
            cyc++;
            if (stall_left > 0) stall_left--;
            if (job_seq != seen_seq) begin
                seen_seq = job_seq;
                idx = 0; acc = '0; pop_cnt = 0; fin_cnt = 0; done_cnt = 0;
                wait_cycles = 0; proto_err = 0; done_cyc = 0;
                stall_left = job_stall + 1;
                start_cyc = cyc;
            end
            if (mac_a_finished) fin_cnt++;
            if (done) begin
                if (done_cnt == 0) done_cyc = cyc;
                done_cnt++;
            end
            if (mac_a_waiting) wait_cycles++;
            if (mac_a_waiting !== mac_b_waiting || mac_a_finished !== mac_b_finished) proto_err++;
            if (!mac_a_ready) begin
                mac_a_ready = 1'b1;
                mac_b_ready = 1'b1;
                wcnt = 0;
            end else if (mac_a_waiting) begin
                wcnt++;
                if (wcnt == 1) first_a = mac_a;
                if (wcnt == 2) begin
                    if (mac_a !== first_a) proto_err++;
                    mac_a_ready = 1'b0;
                    mac_b_ready = 1'b0;
                    acc = acc + mac_a * mac_b;
                end
            end
            mac_c = acc;
        end
        a_valid = rst && (idx < job_k);
        b_valid = a_valid && (stall_left == 0);
        a_data = (idx < 4) ? job_a[idx] : '0;
        b_data = (idx < 4) ? job_b[idx] : '0;
        #2;
        exp_pop = rst && mac_a_waiting && !mac_a_ready;
        if (a_pop !== exp_pop || b_pop !== exp_pop) proto_err++;
        if (a_pop === 1'b1) begin
            pop_cnt++;
            idx++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input vec_t v, input int id);
        bit seen;
        job_k = v.k; job_a = v.a; job_b = v.b; job_stall = v.stall;
        job_seq++;
        start = 1'b1;
        k_len = KW'(v.k);
        step();
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (v.restart_at > 0 && i == v.restart_at) begin
                start = 1'b1;
                k_len = KW'(7);
            end else begin
                start = 1'b0;
            end
            if (v.stall > 0 && i == 3) begin
                check("stall_no_pop", pop_cnt, 0);
                check("stall_no_wait", wait_cycles, 0);
                check("stall_busy", busy, 1);
            end
            step();
            if (done_cnt != 0) seen = 1;
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        repeat (3) step();
        $display("job %0d: k=%0d pops=%0d fin=%0d done=%0d c_result=%0d", id, v.k, pop_cnt, fin_cnt, done_cnt, c_result);
        check("pops", pop_cnt, v.k);
        check("wait_cycles", wait_cycles, 2 * v.k);
        check("fin_cycles", fin_cnt, FH);
        check("done_once", done_cnt, 1);
        check("c_result", c_result, v.exp_c);
        check("busy_idle", busy, 0);
        check("protocol", proto_err, 0);
        if (v.k == 0) check("done_latency", done_cyc - start_cyc, 4);
`ifdef MAC_SEQ_PERF_EN
        check("stall_cnt", stall_cnt, v.k + v.stall);
`endif
    endtask

    task automatic check_outputs_zero(input string tag);
        $display("%s: busy=%0d done=%0d c_result=%0d mac_a=%0d", tag, busy, done, c_result, mac_a);
        check("rst_mac_a", mac_a, 0);
        check("rst_mac_b", mac_b, 0);
        check("rst_waiting", {mac_a_waiting, mac_b_waiting}, 0);
        check("rst_finished", {mac_a_finished, mac_b_finished}, 0);
        check("rst_pop", {a_pop, b_pop}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_c_result", c_result, 0);
`ifdef MAC_SEQ_PERF_EN
        check("rst_stall_cnt", stall_cnt, 0);
`endif
    endtask

    vec_t vecs[6];

    initial begin
        bit got_wait;
        vecs[0] = mk(3, 1, 2, 3, 0, 4, 5, 6, 0, 0, 0, 32);
        vecs[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2] = mk(2, 2, 4, 0, 0, 3, 5, 0, 0, 5, 0, 26);
        vecs[3] = mk(2, 10, 20, 0, 0, 1, 2, 0, 0, 3, 1, 50);
        vecs[4] = mk(4, 1, 1, 1, 1, 10, 20, 30, 40, 0, 0, 100);
        vecs[5] = mk(1, 7, 0, 0, 0, 9, 0, 0, 0, 0, 0, 63);

        repeat (3) step();
        check_outputs_zero("power-on reset");
        rst = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 6; i++) run_job(vecs[i], i);

        // Abort a job while operands are waiting on the MAC.
        job_k = 3; job_a = {32'd0, 32'd5, 32'd5, 32'd5}; job_b = {32'd0, 32'd5, 32'd5, 32'd5};
        job_stall = 0;
        job_seq++;
        start = 1'b1;
        k_len = KW'(3);
        step();
        start = 1'b0;
        got_wait = 0;
        for (int i = 0; i < 50 && !got_wait; i++) begin
            if (mac_a_waiting) got_wait = 1;
            else step();
        end
        check("reach_issue", got_wait, 1);
        rst = 1'b0;
        #1;
        check_outputs_zero("reset in ISSUE");
        repeat (3) step();
        rst = 1'b1;
        repeat (4) step();
        check("abort_no_done", done_cnt, 0);
        check("abort_no_pop", pop_cnt, 0);
        check("abort_idle", busy, 0);
        run_job(mk(1, 6, 0, 0, 0, 7, 0, 0, 0, 0, 0, 42), 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
